// File: rtl/adc16dv160_frame_packer.sv
// Packs 16-bit ADC samples into 32-bit AXI-Stream words, dsize words per frame, through a small FWFT FIFO.
// Optional ramp test pattern: define ADC16DV160_FRAME_PACKER_TEST_PATTERN_EN.
module adc16dv160_frame_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVF_W      = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             s_valid,
  input  logic [15:0]      s_data,
  input  logic             start,
  input  logic             rt,
  input  logic             sync,
  input  logic             test,
  input  logic [31:0]      dsize,
  output logic             m_axis_tvalid,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             done,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic [1:0]       fsm_state
);

  // AXIS handshake: a word transfers on a rising ACLK edge where m_axis_tvalid and
  // m_axis_tready are both high; tvalid never drops and tdata/tlast never change until then.

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DRAIN = 2'd3} state_t;

  state_t      state;
  logic [31:0] dsize_q;
  logic [31:0] wcnt;
  logic        phase;
  logic [15:0] low;
  logic [15:0] ramp;
  logic        sync_d;

  logic [32:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        full;
  logic        wr_req;
  logic        do_write;
  logic        do_read;
  logic        is_last;
  logic [15:0] sample;
  logic [31:0] wdata;

`ifdef ADC16DV160_FRAME_PACKER_TEST_PATTERN_EN
  assign sample = test ? ramp : s_data;
`else
  logic unused_test;
  assign unused_test = test ^ (|ramp);
  assign sample      = s_data;
`endif

  // Full is taken from the registered count, so a same-cycle read never frees a slot for the write.
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign wr_req   = (state == CAPTURE) && s_valid && phase;
  assign do_write = wr_req && !full;
  assign do_read  = m_axis_tvalid && m_axis_tready;
  assign is_last  = (wcnt == dsize_q - 32'd1);
  assign wdata    = {sample, low};

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = mem[rd_ptr][31:0];
  assign m_axis_tlast  = m_axis_tvalid && mem[rd_ptr][32];
  assign m_axis_tkeep  = 4'hF;
  assign busy          = (state != IDLE);
  assign fsm_state     = state;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      dsize_q <= '0;
      wcnt    <= '0;
      phase   <= 1'b0;
      low     <= '0;
      ramp    <= '0;
      sync_d  <= 1'b0;
      done    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      sync_d <= sync;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (dsize != 32'd0)) begin
            dsize_q <= dsize;
            ovf_cnt <= '0;
            wcnt    <= '0;
            phase   <= 1'b0;
            ramp    <= '0;
            state   <= rt ? CAPTURE : ARMED;
          end
        end
        ARMED: begin
          if (sync && !sync_d) begin
            wcnt  <= '0;
            phase <= 1'b0;
            ramp  <= '0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (s_valid) begin
            phase <= ~phase;
            ramp  <= ramp + 16'd1;
            if (!phase) low <= sample;
          end
          // Dropped words are not counted, so the frame always delivers dsize words.
          if (do_write) begin
            wcnt <= wcnt + 32'd1;
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (do_read && m_axis_tlast) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (wr_req && full && (ovf_cnt != {OVF_W{1'b1}})) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_write) mem[wr_ptr] <= {is_last, wdata};
  end

endmodule

// File: tb/tb_adc16dv160_frame_packer.sv
// Directed bench for adc16dv160_frame_packer; expected words are queued by the driver and popped by a monitor.
// Define ADC16DV160_FRAME_PACKER_TEST_PATTERN_EN to also exercise the ramp pattern.
module tb_adc16dv160_frame_packer;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        s_valid, start, rt, sync, test, m_axis_tready;
  logic [15:0] s_data;
  logic [31:0] dsize;
  logic        m_axis_tvalid, m_axis_tlast, busy, done;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic [15:0] ovf_cnt;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int word_cnt = 0;
  logic pending_done = 1'b0;
  logic [36:0] exp_q[$];

  adc16dv160_frame_packer #(.FIFO_DEPTH(16), .OVF_W(16)) dut (
    .ACLK(clk), .ARESET(ARESET), .s_valid(s_valid), .s_data(s_data), .start(start),
    .rt(rt), .sync(sync), .test(test), .dsize(dsize),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .ovf_cnt(ovf_cnt), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] hi, input logic [15:0] lo, input logic last);
    exp_q.push_back({4'hF, last, hi, lo});
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 37'(exp_q.size()), 37'd0);
      exp_q.delete();
    end
    step();
    step();
  endtask

  // scoreboard monitor: compares every handshaken word and the done pulse timing
  always @(negedge clk) begin
    if (pending_done || done) chk("done_pulse", 37'(done), 37'(pending_done));
    if (done === 1'b1) done_cnt++;
    pending_done = 1'b0;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      word_cnt++;
      pending_done = m_axis_tlast;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {m_axis_tkeep, m_axis_tlast, m_axis_tdata}, 37'd0);
      end else begin
        chk("word", {m_axis_tkeep, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int d0;
    ARESET = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0; rt = 1'b0;
    sync = 1'b0; test = 1'b0; dsize = '0; m_axis_tready = 1'b1;
    #2;
    chk("reset_outputs", {m_axis_tvalid, m_axis_tlast, busy, done}, 37'd0);
    chk("reset_ovf", 37'(ovf_cnt), 37'd0);
    chk("reset_state", 37'(fsm_state), 37'd0);
    step(); step();
    ARESET = 1'b0;
    step();

    // real-time frame, dsize=4
    start = 1'b1; rt = 1'b1; dsize = 32'd4;
    for (int p = 0; p < 4; p++) push_word(16'h1000 + 16'(2*p+1), 16'h1000 + 16'(2*p), p == 3);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 16'h1000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    wait_empty(50);
    chk("t1_done_cnt", 37'(done_cnt), 37'd1);
    chk("t1_busy", 37'(busy), 37'd0);

    // armed frame: samples before the sync edge are discarded
    start = 1'b1; rt = 1'b0; dsize = 32'd2;
    push_word(16'h2016, 16'h2015, 1'b0);
    push_word(16'h2018, 16'h2017, 1'b1);
    step();
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      s_valid = 1'b1; s_data = 16'h2000 + 16'(i); sync = (i >= 20);
      if (i == 19) begin
        chk("t2_no_word_before_sync", 37'(m_axis_tvalid), 37'd0);
        chk("t2_state_armed", 37'(fsm_state), 37'd1);
      end
      step();
    end
    s_valid = 1'b0; sync = 1'b0;
    wait_empty(50);
    chk("t2_done_cnt", 37'(done_cnt), 37'd2);

    // overflow: 40 stalled cycles, 20 write attempts into 16 slots
    start = 1'b1; rt = 1'b1; dsize = 32'd64; m_axis_tready = 1'b0;
    for (int p = 0; p < 68; p++)
      if (p < 16 || p >= 20) push_word(16'h3000 + 16'(2*p+1), 16'h3000 + 16'(2*p), p == 67);
    d0 = word_cnt;
    step();
    start = 1'b0;
    for (int c = 1; c <= 136; c++) begin
      s_valid = 1'b1; s_data = 16'h3000 + 16'(c-1); m_axis_tready = (c > 40);
      step();
    end
    s_valid = 1'b0;
    wait_empty(200);
    chk("t3_ovf_cnt", 37'(ovf_cnt), 37'd4);
    chk("t3_word_cnt", 37'(word_cnt - d0), 37'd64);
    chk("t3_done_cnt", 37'(done_cnt), 37'd3);

    // ignored starts: dsize=0, then start while busy
    start = 1'b1; rt = 1'b1; dsize = 32'd0;
    step();
    start = 1'b0;
    step();
    chk("t4_zero_busy", 37'(busy), 37'd0);
    chk("t4_zero_keeps_ovf", 37'(ovf_cnt), 37'd4);
    start = 1'b1; rt = 1'b0; dsize = 32'd1;
    push_word(16'h4002, 16'h4001, 1'b1);
    step();
    start = 1'b0;
    chk("t4_armed", 37'(fsm_state), 37'd1);
    chk("t4_ovf_cleared", 37'(ovf_cnt), 37'd0);
    start = 1'b1; rt = 1'b1; dsize = 32'd5;
    step();
    start = 1'b0;
    step();
    chk("t4_busy_start_ignored", 37'(fsm_state), 37'd1);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 16'h4000 + 16'(i); sync = 1'b1;
      step();
    end
    s_valid = 1'b0; sync = 1'b0;
    wait_empty(50);
    chk("t4_done_cnt", 37'(done_cnt), 37'd4);

    // asynchronous reset mid-capture, then a clean frame
    start = 1'b1; rt = 1'b1; dsize = 32'd8; m_axis_tready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 16'h5000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    chk("t5_tvalid_before_reset", 37'(m_axis_tvalid), 37'd1);
    ARESET = 1'b1;
    #1;
    chk("t5_async_clear", {m_axis_tvalid, busy, done}, 37'd0);
    #1;
    ARESET = 1'b0;
    m_axis_tready = 1'b1;
    step();
    start = 1'b1; rt = 1'b1; dsize = 32'd2;
    push_word(16'h6001, 16'h6000, 1'b0);
    push_word(16'h6003, 16'h6002, 1'b1);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'h6000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    wait_empty(50);
    chk("t5_done_cnt", 37'(done_cnt), 37'd5);

`ifdef ADC16DV160_FRAME_PACKER_TEST_PATTERN_EN
    // ramp pattern replaces s_data
    start = 1'b1; rt = 1'b1; dsize = 32'd2; test = 1'b1;
    push_word(16'h0001, 16'h0000, 1'b0);
    push_word(16'h0003, 16'h0002, 1'b1);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'hBEEF;
      step();
    end
    s_valid = 1'b0; test = 1'b0;
    wait_empty(50);
    chk("t6_done_cnt", 37'(done_cnt), 37'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
